alu_op_decoder: RTL and testbench
=================================

ALU_OP_DECODER -- requirements
Module: alu_op_decoder

Interface
REQ-001 SHALL have clock and reset ports: clk input 1, the single clock, all state rising-edge; reset_n input 1, reset synchronous, active-low.
REQ-002 SHALL have ports: in_valid input 1 (upstream offers instruction); in_ready output 1 (decoder can accept); opcode input 6; funct input 6; rs_data input 32; rt_data input 32; imm input 16.
REQ-003 SHALL have ports: out_valid output 1; out_ready input 1 (ALU side accepts); a output 32; b output 32; func output 3 (ALU function code); is_branch output 1; illegal output 1.

Function
REQ-004 SHALL transfer in on clk edge when in_valid && in_ready, and out when out_valid && out_ready.
REQ-005 SHALL buffer decoded entries in a 2-entry FIFO; in_ready = (count < 2), a registered value independent of out_ready in the same cycle.
REQ-006 SHALL present the FIFO head on a/b/func/is_branch/illegal with out_valid = (count > 0); latency in-accept to out_valid = 1 cycle when empty.
REQ-007 SHALL hold head outputs stable while out_valid && !out_ready.
REQ-008 SHALL, on simultaneous push and pop with count=1, keep count=1 and present the new entry next cycle; push and pop at count=0 is impossible (out_valid low).
REQ-009 SHALL decode opcode 00h R-type by funct: 20h->0, 22h->1, 24h->2, 25h->3, 27h->4, 2Ah->5; a=rs_data, b=rt_data.
REQ-010 SHALL decode I-type: 08h ADDI->0, b=sign-extended imm; 0Ah SLTI->5, b=sign-extended imm; 0Ch ANDI->2, b=zero-extended imm; 0Dh ORI->3, b=zero-extended imm; a=rs_data.
REQ-011 SHALL decode 04h BEQ->1 (subtract), a=rs_data, b=rt_data, is_branch=1; is_branch=0 for all others.
REQ-012 SHALL map any other opcode or R-type funct to func=6, a=0, b=0, illegal=1; illegal entries are queued and drained like legal ones, never dropped.
REQ-013 SHALL ignore opcode/funct/data inputs when in_valid=0 or in_ready=0.
REQ-014 SHALL implement FIFO pointers as 1-bit wrapping indices; count SHALL never exceed 2 or go below 0.

Reset
REQ-015 SHALL, on a clk edge with reset_n=0, clear count and pointers; out_valid=0, in_ready=0 during reset, in_ready=1 first cycle after release.
REQ-016 SHALL reset a=0, b=0, func=0, is_branch=0, illegal=0.
REQ-017 SHALL discard buffered entries when reset asserts mid-operation; no entry reappears after release.

Configuration
REQ-018 SHALL use macro ALU_DEC_STATS_EN to compile in statistics.
REQ-019 SHALL, with ALU_DEC_STATS_EN defined, add outputs issued_count 16 and illegal_count 16: incremented per output transfer (illegal_count only for illegal=1 entries), saturating at FFFFh, reset to 0.
REQ-020 SHALL, without ALU_DEC_STATS_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-021 R-type ADD: opcode 00h, funct 20h, rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, func=0, a=5, b=7, illegal=0.
REQ-022 ADDI sign-extend: opcode 08h, imm=FFFEh, rs=10 -> b=FFFF_FFFEh, func=0; ORI imm=8000h -> b=0000_8000h, func=3.
REQ-023 Backpressure: out_ready=0, offer 3 instructions back-to-back -> 2 accepted, in_ready=0 after second; out_ready=1 -> drained in order, in_ready reasserts.
REQ-024 Illegal: opcode 3Fh -> func=6, a=0, b=0, illegal=1; with ALU_DEC_STATS_EN illegal_count=1, issued_count=1 after transfer.
REQ-025 BEQ + reset: opcode 04h rs=rt=9 -> func=1, is_branch=1; queue 2 entries, pulse reset_n=0 one cycle -> out_valid=0, no stale entry after release.

Source files
------------

// File: rtl/alu_op_decoder.sv
// ALU operand/function decoder feeding a 2-entry output FIFO with valid/ready on both sides.
// Optional statistics counters are compiled in with ALU_DEC_STATS_EN.
module alu_op_decoder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [15:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [2:0]  func,
    output logic        is_branch,
    output logic        illegal
`ifdef ALU_DEC_STATS_EN
    ,
    output logic [15:0] issued_count,
    output logic [15:0] illegal_count
`endif
);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  func;
        logic        is_branch;
        logic        illegal;
    } entry_t;

    entry_t     dec;
    entry_t     mem_q [2];
    entry_t     head;
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       in_ready_q;
    logic       push;
    logic       pop;

    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};

    // Unrecognised encodings fall through to the illegal entry with zeroed operands.
    always_comb begin
        dec           = '0;
        dec.func      = 3'd6;
        dec.illegal   = 1'b1;
        unique case (opcode)
            6'h00: begin
                dec.a       = rs_data;
                dec.b       = rt_data;
                dec.illegal = 1'b0;
                unique case (funct)
                    6'h20:   dec.func = 3'd0;
                    6'h22:   dec.func = 3'd1;
                    6'h24:   dec.func = 3'd2;
                    6'h25:   dec.func = 3'd3;
                    6'h27:   dec.func = 3'd4;
                    6'h2A:   dec.func = 3'd5;
                    default: begin
                        dec.a       = '0;
                        dec.b       = '0;
                        dec.func    = 3'd6;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            6'h08: dec = '{a: rs_data, b: imm_sext, func: 3'd0, is_branch: 1'b0, illegal: 1'b0};
            6'h0A: dec = '{a: rs_data, b: imm_sext, func: 3'd5, is_branch: 1'b0, illegal: 1'b0};
            6'h0C: dec = '{a: rs_data, b: imm_zext, func: 3'd2, is_branch: 1'b0, illegal: 1'b0};
            6'h0D: dec = '{a: rs_data, b: imm_zext, func: 3'd3, is_branch: 1'b0, illegal: 1'b0};
            6'h04: dec = '{a: rs_data, b: rt_data, func: 3'd1, is_branch: 1'b1, illegal: 1'b0};
            default: ;
        endcase
    end

    assign push = in_valid && in_ready_q;
    assign pop  = (count_q != 2'd0) && out_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 2'd1;
        else if (pop && !push)
            count_d = count_q - 2'd1;
    end

    // in_ready is held low through reset and follows the next-state occupancy afterwards,
    // so it never depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            if (push)
                mem_q[wr_ptr_q] <= dec;
            wr_ptr_q   <= wr_ptr_q ^ push;
            rd_ptr_q   <= rd_ptr_q ^ pop;
            count_q    <= count_d;
            in_ready_q <= (count_d < 2'd2);
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign a         = head.a;
    assign b         = head.b;
    assign func      = head.func;
    assign is_branch = head.is_branch;
    assign illegal   = head.illegal;

`ifdef ALU_DEC_STATS_EN
    logic [15:0] issued_q;
    logic [15:0] illegal_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            issued_q  <= 16'h0000;
            illegal_q <= 16'h0000;
        end else if (pop) begin
            if (issued_q != 16'hFFFF)
                issued_q <= issued_q + 16'h0001;
            if (head.illegal && (illegal_q != 16'hFFFF))
                illegal_q <= illegal_q + 16'h0001;
        end
    end

    assign issued_count  = issued_q;
    assign illegal_count = illegal_q;
`endif

endmodule

// File: tb/tb_alu_op_decoder.sv
// Bench for alu_op_decoder: directed scenarios then random traffic against a queue-based model.
// Stats checks are active when ALU_DEC_STATS_EN is defined.
module tb_alu_op_decoder;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  func;
    logic        is_branch;
    logic        illegal;
`ifdef ALU_DEC_STATS_EN
    logic [15:0] issued_count;
    logic [15:0] illegal_count;
`endif

    alu_op_decoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funct     (funct),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .func      (func),
        .is_branch (is_branch),
        .illegal   (illegal)
`ifdef ALU_DEC_STATS_EN
        ,
        .issued_count  (issued_count),
        .illegal_count (illegal_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          fn;
        bit          br;
        bit          ill;
    } exp_t;

    exp_t q[$];
    bit   exp_ready;
    int   exp_issued;
    int   exp_illegal;
    int   total;
    int   bad;

    function automatic exp_t ref_dec(input int op, input int fc, input logic [31:0] rs,
                                     input logic [31:0] rt, input logic [15:0] im);
        exp_t e;
        logic [31:0] sx;
        logic [31:0] zx;
        zx = 32'(im);
        sx = (im >= 16'h8000) ? zx + 32'hFFFF_0000 : zx;
        e = '{a: 32'd0, b: 32'd0, fn: 6, br: 1'b0, ill: 1'b1};
        if (op == 0) begin
            case (fc)
                'h20: e = '{rs, rt, 0, 1'b0, 1'b0};
                'h22: e = '{rs, rt, 1, 1'b0, 1'b0};
                'h24: e = '{rs, rt, 2, 1'b0, 1'b0};
                'h25: e = '{rs, rt, 3, 1'b0, 1'b0};
                'h27: e = '{rs, rt, 4, 1'b0, 1'b0};
                'h2A: e = '{rs, rt, 5, 1'b0, 1'b0};
                default: ;
            endcase
        end
        else if (op == 'h08) e = '{rs, sx, 0, 1'b0, 1'b0};
        else if (op == 'h0A) e = '{rs, sx, 5, 1'b0, 1'b0};
        else if (op == 'h0C) e = '{rs, zx, 2, 1'b0, 1'b0};
        else if (op == 'h0D) e = '{rs, zx, 3, 1'b0, 1'b0};
        else if (op == 'h04) e = '{rs, rt, 1, 1'b1, 1'b0};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: model the handshake seen before the edge, then compare at the falling edge.
    task automatic cycle();
        bit   acc;
        bit   pop;
        exp_t nd;
        acc = reset_n && in_valid && exp_ready;
        pop = reset_n && (q.size() > 0) && out_ready;
        nd  = ref_dec(int'(opcode), int'(funct), rs_data, rt_data, imm);
        @(posedge clk);
        if (!reset_n) begin
            q.delete();
            exp_ready   = 1'b0;
            exp_issued  = 0;
            exp_illegal = 0;
        end else begin
            if (pop) begin
                if (exp_issued < 65535) exp_issued++;
                if (q[0].ill && exp_illegal < 65535) exp_illegal++;
                void'(q.pop_front());
            end
            if (acc) q.push_back(nd);
            exp_ready = (q.size() < 2);
        end
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        if (q.size() > 0) begin
            chk("a", a, q[0].a);
            chk("b", b, q[0].b);
            chk("func", 32'(func), 32'(q[0].fn));
            chk("is_branch", 32'(is_branch), 32'(q[0].br));
            chk("illegal", 32'(illegal), 32'(q[0].ill));
        end
`ifdef ALU_DEC_STATS_EN
        chk("issued_count", 32'(issued_count), 32'(exp_issued));
        chk("illegal_count", 32'(illegal_count), 32'(exp_illegal));
`endif
    endtask

    task automatic drive(input bit v, input logic [5:0] op, input logic [5:0] fc,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im);
        in_valid = v;
        opcode   = op;
        funct    = fc;
        rs_data  = rs;
        rt_data  = rt;
        imm      = im;
    endtask

    logic [5:0] ops [8];
    logic [5:0] fns [7];

    initial begin
        total = 0;
        bad   = 0;
        exp_ready = 1'b0;
        exp_issued = 0;
        exp_illegal = 0;
        ops = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h04, 6'h3F, 6'h00};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h21};

        reset_n   = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 6'h00, 6'h20, 32'd1, 32'd2, 16'd3);
        cycle();
        cycle();
        chk("rst_a", a, 32'd0);
        chk("rst_b", b, 32'd0);
        chk("rst_func", 32'(func), 32'd0);
        chk("rst_is_branch", 32'(is_branch), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);

        reset_n = 1'b1;
        drive(1'b0, 6'h00, 6'h20, 32'd1, 32'd2, 16'd3);
        cycle();
        chk("ready_after_release", 32'(in_ready), 32'd1);

        // R-type ADD, single entry, 1-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 6'h00, 6'h20, 32'd5, 32'd7, 16'd0);
        cycle();
        chk("add_func", 32'(func), 32'd0);
        chk("add_a", a, 32'd5);
        chk("add_b", b, 32'd7);
        drive(1'b0, 6'h00, 6'h20, 32'd0, 32'd0, 16'd0);
        cycle();

        // ADDI sign extension, then ORI zero extension
        drive(1'b1, 6'h08, 6'h00, 32'd10, 32'd0, 16'hFFFE);
        cycle();
        chk("addi_b", b, 32'hFFFF_FFFE);
        drive(1'b1, 6'h0D, 6'h00, 32'd10, 32'd0, 16'h8000);
        cycle();
        chk("ori_b", b, 32'h0000_8000);
        chk("ori_func", 32'(func), 32'd3);
        drive(1'b0, 6'h00, 6'h00, 32'd0, 32'd0, 16'd0);
        cycle();

        // backpressure: three offers, only two fit
        out_ready = 1'b0;
        drive(1'b1, 6'h00, 6'h22, 32'd100, 32'd1, 16'd0);
        cycle();
        drive(1'b1, 6'h0C, 6'h00, 32'd200, 32'd0, 16'hF0F0);
        cycle();
        chk("bp_full", 32'(in_ready), 32'd0);
        drive(1'b1, 6'h00, 6'h25, 32'd300, 32'd3, 16'd0);
        cycle();
        cycle();
        drive(1'b0, 6'h00, 6'h00, 32'd0, 32'd0, 16'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // illegal opcode queued and drained
        drive(1'b1, 6'h3F, 6'h20, 32'd55, 32'd66, 16'h1234);
        cycle();
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_func", 32'(func), 32'd6);
        drive(1'b0, 6'h00, 6'h00, 32'd0, 32'd0, 16'd0);
        cycle();

        // BEQ, then reset with two entries buffered
        out_ready = 1'b0;
        drive(1'b1, 6'h04, 6'h00, 32'd9, 32'd9, 16'd4);
        cycle();
        chk("beq_branch", 32'(is_branch), 32'd1);
        chk("beq_func", 32'(func), 32'd1);
        drive(1'b1, 6'h00, 6'h2A, 32'd1, 32'd2, 16'd0);
        cycle();
        reset_n = 1'b0;
        drive(1'b0, 6'h00, 6'h00, 32'd0, 32'd0, 16'd0);
        cycle();
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // random traffic, including input changes while not accepted
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)],
                  ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)],
                  $urandom, $urandom, 16'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
